// File: rtl/raw_serial_pkg.sv
// Shared definitions for the raw serial receiver and transmitter: data width, default divider, FSM encoding.
// The PARITY state exists only when RAW_SERIAL_RX_PARITY_EN is defined.
package raw_serial_pkg;

  localparam int DATA_W          = 8;
  localparam int DEFAULT_CLK_DIV = 625;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef RAW_SERIAL_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/raw_serial_rx_if.sv
// Received-byte stream: data/valid from the receiver, ready from the consumer.
// valid/ready: a byte transfers on a cycle where valid && ready; data is stable while valid is high.
interface raw_serial_rx_if;
  import raw_serial_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/raw_serial_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module raw_serial_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/raw_serial_rx.sv
// Oversampling-free UART receiver (8N1, or 8E1 when RAW_SERIAL_RX_PARITY_EN is defined) sampling at bit centres.
// Bytes are offered on a valid/ready stream; a byte arriving while the previous one is unconsumed is dropped.
module raw_serial_rx
  import raw_serial_pkg::*;
#(
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  raw_serial_rx_if.master   out_if,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err,
  output rx_state_e         state_o
);

  localparam int                CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);

  logic rxd_s;

  raw_serial_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              rxd_prev_q;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              expired;
  logic              complete;
`ifdef RAW_SERIAL_RX_PARITY_EN
  logic              par_err_q, par_err_d;
  logic              par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      rxd_prev_q  <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RAW_SERIAL_RX_PARITY_EN
      par_err_q   <= 1'b0;
      par_bad_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rxd_prev_q  <= rxd_s;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef RAW_SERIAL_RX_PARITY_EN
      par_err_q   <= par_err_d;
      par_bad_q   <= par_bad_d;
`endif
    end
  end

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;
`ifdef RAW_SERIAL_RX_PARITY_EN
    par_err_d   = 1'b0;
    par_bad_d   = par_bad_q;
`endif

    // The bit timer free-runs down to zero in the in-frame states and parks there.
    if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH && !expired) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (rxd_prev_q && !rxd_s) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (expired) begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = '0;
`ifdef RAW_SERIAL_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
      end
      ST_DATA: begin
        if (expired) begin
          shift_d = {rxd_s, shift_q[DATA_W-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef RAW_SERIAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef RAW_SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (expired) begin
          state_d = ST_STOP;
          cnt_d   = FULL_LOAD;
          if (even_parity(shift_q) != rxd_s) begin
            par_err_d = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (expired) begin
          if (rxd_s) begin
            state_d = ST_IDLE;
`ifdef RAW_SERIAL_RX_PARITY_EN
            complete = !par_bad_q;
`else
            complete = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A consume and a new byte in the same cycle reload rather than clear.
    if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || out_if.ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign state_o      = state_q;
`ifdef RAW_SERIAL_RX_PARITY_EN
  assign parity_err   = par_err_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
